// File: rtl/memory_port_sram_target_if.sv
// memory_port_sram_target_if: memory-port command/response and SRAM pin bundle
interface memory_port_sram_target_if #(
   parameter int address_bus_width = 23,
   parameter int data_bus_width = 1
);
   logic [address_bus_width-1:0] address;
   logic [8*data_bus_width-1:0] d_to_target;
   logic access;
   logic [data_bus_width-1:0] mask;
   logic write;
   logic [8*data_bus_width-1:0] d_to_initiator;
   logic ready;
   logic data_ready;
   logic [address_bus_width-1:0] sram_address;
   logic [8*data_bus_width-1:0] sram_data_out;
   logic [8*data_bus_width-1:0] sram_data_in;
   logic sram_data_oe;
   logic sram_ce_n;
   logic sram_oe_n;
   logic sram_we_n;
   logic [data_bus_width-1:0] sram_be_n;
   modport slave (
      input  address, d_to_target, access, mask, write, sram_data_in,
      output d_to_initiator, ready, data_ready, sram_address, sram_data_out,
             sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
   );
   modport master (
      output address, d_to_target, access, mask, write, sram_data_in,
      input  d_to_initiator, ready, data_ready, sram_address, sram_data_out,
             sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
   );
endinterface

// File: rtl/memory_port_sram_target.sv
// memory_port_sram_target: queued memory-port target driving an async SRAM with wait states
module memory_port_sram_target #(
   parameter int address_bus_width = 23,
   parameter int data_bus_width = 1,
   parameter int wait_states = 2,
   parameter int cmd_depth = 4
) (
   input logic clk,
   input logic reset,
   memory_port_sram_target_if.slave bus
);
   localparam int dw = 8 * data_bus_width;
   localparam int pw = $clog2(cmd_depth);
   localparam int cw = wait_states > 0 ? $clog2(wait_states + 1) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
   state_t state, state_nx;
   logic [address_bus_width-1:0] q_addr [cmd_depth];
   logic [dw-1:0] q_data [cmd_depth];
   logic [data_bus_width-1:0] q_mask [cmd_depth];
   logic [cmd_depth-1:0] q_write;
   logic [pw-1:0] wr_ptr, rd_ptr;
   logic [pw:0] count;
   logic push, pop, capture;
   logic [cw-1:0] cnt, cnt_nx;
   logic [address_bus_width-1:0] cmd_addr;
   logic [dw-1:0] cmd_data, rd_data;
   logic cmd_write;
   logic ce_n, oe_n, we_n, doe, data_ready;
   logic ce_nx, oe_nx, we_nx, doe_nx;
   logic [data_bus_width-1:0] be_n, be_nx;
   assign bus.ready = count < (pw + 1)'(cmd_depth);
   assign push = bus.access && bus.ready;
   assign pop = (state == IDLE) && (count != '0);
   // FIFO storage: written on accept, never reset since occupancy lives in count
   always_ff @(posedge clk)
      if (push) begin
         q_addr[wr_ptr] <= bus.address;
         q_data[wr_ptr] <= bus.d_to_target;
         q_mask[wr_ptr] <= bus.mask;
         q_write[wr_ptr] <= bus.write;
      end
   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + pw'(push);
         rd_ptr <= rd_ptr + pw'(pop);
         count <= count + (pw + 1)'(push) - (pw + 1)'(pop);
      end
   // FSM state and wait-state counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   // Next state and next strobe values; strobes hold unless a transition changes them
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      ce_nx = ce_n;
      oe_nx = oe_n;
      we_nx = we_n;
      be_nx = be_n;
      doe_nx = doe;
      capture = 1'b0;
      case (state)
         IDLE:
            if (pop) begin
               state_nx = ACCESS;
               cnt_nx = cw'(wait_states);
               ce_nx = 1'b0;
               oe_nx = q_write[rd_ptr];
               we_nx = !q_write[rd_ptr];
               be_nx = q_write[rd_ptr] ? ~q_mask[rd_ptr] : '0;
               doe_nx = q_write[rd_ptr];
            end
         ACCESS:
            if (cnt == '0) begin
               state_nx = RECOVER;
               capture = !cmd_write;
               ce_nx = 1'b1;
               oe_nx = 1'b1;
               we_nx = 1'b1;
               be_nx = '1;
            end else
               cnt_nx = cnt - 1'b1;
         RECOVER: begin
            state_nx = IDLE;
            doe_nx = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
   end
   // Registered command, SRAM strobes and read response
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cmd_addr <= '0;
         cmd_data <= '0;
         cmd_write <= 1'b0;
         ce_n <= 1'b1;
         oe_n <= 1'b1;
         we_n <= 1'b1;
         be_n <= '1;
         doe <= 1'b0;
         data_ready <= 1'b0;
         rd_data <= '0;
      end else begin
         if (pop) begin
            cmd_addr <= q_addr[rd_ptr];
            cmd_data <= q_data[rd_ptr];
            cmd_write <= q_write[rd_ptr];
         end
         ce_n <= ce_nx;
         oe_n <= oe_nx;
         we_n <= we_nx;
         be_n <= be_nx;
         doe <= doe_nx;
         data_ready <= capture;
         if (capture)
            rd_data <= bus.sram_data_in;
      end
   assign bus.sram_address = cmd_addr;
   assign bus.sram_data_out = cmd_data;
   assign bus.sram_data_oe = doe;
   assign bus.sram_ce_n = ce_n;
   assign bus.sram_oe_n = oe_n;
   assign bus.sram_we_n = we_n;
   assign bus.sram_be_n = be_n;
   assign bus.data_ready = data_ready;
   assign bus.d_to_initiator = rd_data;
endmodule

// File: tb/tb_memory_port_sram_target.sv
// tb_memory_port_sram_target: vectors, corner sequences and random traffic against a queue model
module tb_memory_port_sram_target;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   memory_port_sram_target_if #(.address_bus_width(23), .data_bus_width(2)) b();
   memory_port_sram_target #(
      .address_bus_width(23), .data_bus_width(2), .wait_states(2), .cmd_depth(4)
   ) dut (.clk(clk), .reset(reset), .bus(b));
   typedef struct {
      bit wr;
      logic [22:0] addr;
      logic [15:0] data;
      logic [1:0] mask;
      logic [15:0] exp_rd;
      logic [1:0] exp_be;
   } vec_t;
   vec_t vecs[9];
   logic [15:0] sram [256];
   logic [15:0] model_mem [256];
   logic [15:0] exp_q[$], got_q[$];
   int got_cyc[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, starts = 0, ce_low = 0, we_low = 0, dbl = 0;
   logic [1:0] be_or, be_and;
   logic dr_prev = 1'b0, ce_prev = 1'b1;
   // asynchronous SRAM: reads while CE/OE low, writes per enabled byte while CE/WE low and driven
   assign b.sram_data_in = (!b.sram_ce_n && !b.sram_oe_n) ? sram[b.sram_address[7:0]] : 16'h0;
   always @(posedge clk)
      if (!b.sram_ce_n && !b.sram_we_n && b.sram_data_oe)
         for (int i = 0; i < 2; i++)
            if (!b.sram_be_n[i]) sram[b.sram_address[7:0]][8*i +: 8] <= b.sram_data_out[8*i +: 8];
   always @(posedge clk) cyc <= cyc + 1;
   // reference model: commands take effect in acceptance order, reads return the value seen then
   always @(posedge clk)
      if (!reset && b.access && b.ready) begin
         if (b.write) begin
            for (int i = 0; i < 2; i++)
               if (b.mask[i]) model_mem[b.address[7:0]][8*i +: 8] = b.d_to_target[8*i +: 8];
         end else
            exp_q.push_back(model_mem[b.address[7:0]]);
      end
   // response and strobe observation
   always @(negedge clk) begin
      if (b.data_ready) begin
         got_q.push_back(b.d_to_initiator);
         got_cyc.push_back(cyc);
      end
      if (b.data_ready && dr_prev) dbl++;
      dr_prev = b.data_ready;
      if (!b.sram_ce_n) begin
         ce_low++;
         be_or = be_or | b.sram_be_n;
         be_and = be_and & b.sram_be_n;
      end
      if (!b.sram_we_n) we_low++;
      if (!b.sram_ce_n && ce_prev) starts++;
      ce_prev = b.sram_ce_n;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic issue(input bit wr, input logic [22:0] a, input logic [15:0] d,
                        input logic [1:0] m, output int n);
      int g = 0;
      @(negedge clk);
      while (!b.ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("issue_ready", 32'(b.ready), 32'd1);
      b.write = wr;
      b.address = a;
      b.d_to_target = d;
      b.mask = m;
      b.access = 1'b1;
      @(negedge clk);
      b.access = 1'b0;
      n = cyc;
   endtask
   task automatic compare_queues(input string nm);
      chk({nm, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({nm, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask
   task automatic hold_access(input bit wr[6], input logic [22:0] a[6], input int total,
                              output int low_cnt);
      int i = 0, g = 0;
      low_cnt = 0;
      @(negedge clk);
      while (i < total && g < 200) begin
         b.access = 1'b1;
         b.write = wr[i];
         b.address = a[i];
         b.d_to_target = 16'h1111;
         b.mask = 2'b11;
         if (b.ready) i++;
         else low_cnt++;
         @(negedge clk);
         g++;
      end
      b.access = 1'b0;
      chk("hold_accepted", 32'(i), 32'(total));
   endtask
   initial begin
      int n, r0, s0, low, issued;
      bit s_wr[6];
      logic [22:0] s_a[6];
      for (int i = 0; i < 256; i++) begin
         sram[i] = 16'h0;
         model_mem[i] = 16'h0;
      end
      b.access = 1'b0;
      b.write = 1'b0;
      b.address = '0;
      b.d_to_target = '0;
      b.mask = '0;
      vecs[0] = '{1'b1, 23'h10, 16'hA5A5, 2'b11, 16'h0000, 2'b00};
      vecs[1] = '{1'b0, 23'h10, 16'h0000, 2'b00, 16'hA5A5, 2'b00};
      vecs[2] = '{1'b1, 23'h10, 16'h5A5A, 2'b00, 16'h0000, 2'b11};
      vecs[3] = '{1'b0, 23'h10, 16'h0000, 2'b00, 16'hA5A5, 2'b00};
      vecs[4] = '{1'b1, 23'h20, 16'h1234, 2'b11, 16'h0000, 2'b00};
      vecs[5] = '{1'b1, 23'h20, 16'hBEEF, 2'b10, 16'h0000, 2'b01};
      vecs[6] = '{1'b0, 23'h20, 16'h0000, 2'b00, 16'hBE34, 2'b00};
      vecs[7] = '{1'b1, 23'h20, 16'h00CD, 2'b01, 16'h0000, 2'b10};
      vecs[8] = '{1'b0, 23'h20, 16'h0000, 2'b00, 16'hBECD, 2'b00};
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(b.ready), 32'd1);
      chk("rst_strobes", {b.sram_ce_n, b.sram_oe_n, b.sram_we_n, b.sram_be_n}, 32'h1F);
      chk("rst_oe", 32'(b.sram_data_oe), 32'd0);
      chk("rst_addr", 32'(b.sram_address), 32'd0);
      chk("rst_dout", 32'(b.sram_data_out), 32'd0);
      chk("rst_resp", {b.data_ready, b.d_to_initiator}, 32'd0);
      reset = 1'b0;
      for (int v = 0; v < 9; v++) begin
         r0 = got_q.size();
         ce_low = 0;
         we_low = 0;
         be_or = 2'b00;
         be_and = 2'b11;
         issue(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].mask, n);
         repeat (8) @(negedge clk);
         chk("vec_be_or", 32'(be_or), 32'(vecs[v].exp_be));
         chk("vec_be_and", 32'(be_and), 32'(vecs[v].exp_be));
         chk("vec_ce_cycles", 32'(ce_low), 32'd3);
         chk("vec_we_cycles", 32'(we_low), vecs[v].wr ? 32'd3 : 32'd0);
         if (vecs[v].wr)
            chk("vec_write_no_ready", 32'(got_q.size()), 32'(r0));
         else begin
            chk("vec_read_count", 32'(got_q.size()), 32'(r0 + 1));
            chk("vec_read_data", 32'(got_q[$]), 32'(vecs[v].exp_rd));
            chk("vec_read_cycle", 32'(got_cyc[$]), 32'(n + 4));
         end
      end
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      s_wr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      s_a = '{23'h10, 23'h20, 23'h30, 23'h30, 23'h10, 23'h20};
      hold_access(s_wr, s_a, 6, low);
      chk("hold_ready_low_cycles", 32'(low), 32'd2);
      repeat (40) @(negedge clk);
      chk("hold_read_count", 32'(got_q.size()), 32'd5);
      compare_queues("hold");
      s_wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      s_a = '{23'h10, 23'h10, 23'h10, 23'h10, 23'h10, 23'h10};
      s0 = starts;
      hold_access(s_wr, s_a, 5, low);
      chk("full_ready_low", 32'(b.ready), 32'd0);
      b.write = 1'b1;
      b.address = 23'h40;
      b.d_to_target = 16'hDEAD;
      b.mask = 2'b11;
      b.access = 1'b1;
      @(negedge clk);
      b.access = 1'b0;
      repeat (40) @(negedge clk);
      chk("ignored_sram_cycles", 32'(starts - s0), 32'd5);
      compare_queues("ignored");
      issue(1'b0, 23'h40, 16'h0, 2'b00, n);
      repeat (8) @(negedge clk);
      chk("ignored_readback_count", 32'(got_q.size()), 32'd1);
      chk("ignored_readback", 32'(got_q[0]), 32'h0000);
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      issued = 0;
      for (int k = 0; k < 2000 && issued < 60; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) != 0) begin
            b.write = 1'($urandom_range(0, 1));
            b.address = 23'h50 + 23'($urandom_range(0, 7));
            b.d_to_target = 16'($urandom);
            b.mask = 2'($urandom_range(0, 3));
            b.access = 1'b1;
            if (b.ready) issued++;
         end else
            b.access = 1'b0;
      end
      @(negedge clk);
      b.access = 1'b0;
      repeat (60) @(negedge clk);
      chk("rand_issued", 32'(issued), 32'd60);
      compare_queues("rand");
      for (int a = 8'h50; a < 8'h58; a++)
         chk("rand_sram_contents", 32'(sram[a]), 32'(model_mem[a]));
      s0 = starts;
      @(negedge clk);
      b.write = 1'b0;
      b.address = 23'h10;
      b.access = 1'b1;
      repeat (3) @(negedge clk);
      b.access = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_strobes", {b.sram_ce_n, b.sram_oe_n, b.sram_we_n, b.sram_be_n}, 32'h1F);
      chk("mid_rst_oe", 32'(b.sram_data_oe), 32'd0);
      chk("mid_rst_ready", 32'(b.ready), 32'd1);
      chk("mid_rst_dr", 32'(b.data_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      r0 = got_q.size();
      repeat (20) @(negedge clk);
      chk("mid_rst_no_response", 32'(got_q.size()), 32'(r0));
      chk("mid_rst_one_cycle_started", 32'(starts - s0), 32'd1);
      chk("dr_single_pulse", 32'(dbl), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/memory_port_sram_target.md
# memory_port_sram_target

Target-side responder for the Retro-1 memory port: accepts initiator commands (Address/Write/Mask/DToTarget, qualified by Access), buffers them in a small command FIFO, and executes them one at a time against an external asynchronous SRAM with a parameterised number of wait states. Read results return on DToInitiator with a one-cycle DataReady pulse, in command acceptance order. Sits between any memory-port initiator (CPU core, DMA, video fetch) and the board SRAM pins.

## Interface
- AddressBusWidth, 23, address width in words
- DataBusWidth, 1, data width in bytes
- WaitStates, 2, extra SRAM access cycles beyond one (W ≥ 0)
- CmdDepth, 4, command FIFO entries (power of two, ≥ 2)

- Clk  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high
- Address  in  AddressBusWidth  command address
- DToTarget  in  8*DataBusWidth  write data
- Access  in  1  command valid
- Mask  in  DataBusWidth  write byte enables, 1 = write byte
- Write  in  1  1 = write, 0 = read
- DToInitiator  out  8*DataBusWidth  read data, valid while DataReady
- Ready  out  1  command can be accepted
- DataReady  out  1  one-cycle read-completion pulse
- SramAddress  out  AddressBusWidth  SRAM address
- SramDataOut  out  8*DataBusWidth  SRAM write data
- SramDataIn  in  8*DataBusWidth  SRAM read data
- SramDataOe  out  1  drive SRAM data pins
- SramCeN, SramOeN, SramWeN  out  1 each  active-low strobes
- SramBeN  out  DataBusWidth  active-low byte enables

## Operation
- Accept: command pushed on any rising edge with Access && Ready. Access while !Ready ignored (not queued, no response).
- Ready = (FIFO count < CmdDepth), combinational from registered count. Push and pop on the same edge legal; count unchanged.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE: FIFO non-empty → pop head into registered command, load wait counter with WaitStates, go ACCESS. Else stay.
- ACCESS: strobes registered: SramCeN=0; read: SramOeN=0, SramBeN all 0; write: SramWeN=0, SramBeN=~Mask, SramDataOe=1. Counter decrements each cycle; ACCESS lasts W+1 cycles. On the edge leaving ACCESS: read → capture SramDataIn into DToInitiator, set DataReady; → RECOVER.
- RECOVER: one cycle; CeN/OeN/WeN/BeN high; after a write SramDataOe stays 1 (data hold), cleared on exit. → IDLE.
- Write with Mask == 0: full cycle executed, SramBeN all 1, no byte changes.
- Writes never produce DataReady. Reads complete strictly in acceptance order.
- DToInitiator holds last read value until the next read capture.

## Timing
- Per command: 1 IDLE + (W+1) ACCESS + 1 RECOVER = W+3 cycles; sustained throughput one command per W+3 cycles.
- Read accepted at edge N into empty FIFO, FSM IDLE: popped at edge N+1, ACCESS cycles follow edges N+1..N+W+1, capture at edge N+W+2, DataReady high for the cycle after edge N+W+2 (W=2: after edge N+4).
- DataReady high exactly one cycle per read; deasserted on the following edge unless a further capture occurs (impossible within W+3 spacing).
- SramAddress/SramDataOut stable for all ACCESS and RECOVER cycles of a command.
- Reset (async, any state): FIFO empty, state IDLE, SramCeN/OeN/WeN=1, SramBeN all 1, SramDataOe=0, SramAddress=0, SramDataOut=0, DataReady=0, DToInitiator=0, Ready=1. In-flight and queued commands discarded; no DataReady for them.

## Test plan
- W=2: write Address=0x000010, DToTarget=0xA5, Mask=1; then read 0x000010 at edge N → DataReady only in cycle after edge N+4, DToInitiator=0xA5; write yields no DataReady.
- Six commands with Access held high from idle, CmdDepth=4 → Ready low after the FIFO fills, queued commands stay queued, later commands accepted only when Ready rises, all reads return in order.
- Write 0x5A with Mask=0 to address holding 0xA5 → SramBeN=1 throughout, readback 0xA5.
- DataBusWidth=2, write 0xBEEF Mask=2'b10 over 0x1234 → SramBeN=2'b01, readback 0xBE34.
- Access asserted while Ready=0 → not executed, no SRAM cycle, no DataReady.
- Reset asserted mid-ACCESS of a read with two queued → strobes high and SramDataOe=0 immediately, Ready=1, no DataReady afterward.
